snake_engine: RTL and testbench
===============================

# snake_engine

Game-logic core of the FPGA snake design: holds the snake body, applies direction input, moves the snake one cell per `step_tick`, grows it on apple hits, detects border and self collision, and sequences the game status. It sits directly upstream of the VGA display stage and drives that stage's `snake_x_temp`, `snake_y_temp`, `snake_piece_is_display` and `game_status` inputs. Apple placement lives outside this block; here the apple is only compared against.

## Interface
- `MAX_LEN`, 32: segment capacity; it fixes the packed bus widths at `MAX_LEN*6`.
- `INIT_LEN`, 3: snake length after reset or reinitialisation.
- `FLASH_TICKS`, 8: number of `step_tick`s spent in DIE_FLASHING.

- `clock`  in  1  system clock (148.5 MHz domain)
- `rst_n`  in  1  asynchronous, active-low reset
- `step_tick`  in  1  one-cycle pulse that advances the game
- `key_up`, `key_right`, `key_down`, `key_left`  in  1 each  direction requests, sampled every cycle
- `key_start`  in  1  one-cycle pulse: start, or pause/resume
- `apple_x`, `apple_y`  in  6 each  current apple cell
- `snake_x_temp`, `snake_y_temp`  out  MAX_LEN*6  segment i at `[6*i +: 6]`; segment 0 is the head
- `snake_piece_is_display`  out  MAX_LEN  per-segment visible flag
- `game_status`  out  2  PAUSED=00, PLAYING=01, DIE_FLASHING=10, INITIALIZING=11
- `apple_eaten`  out  1  one-cycle pulse when the head lands on the apple
- `snake_len`  out  6  current length, range 3..32

## Operation
- Grid: x 0..48, y 0..26. The border cells are x=0, x=48, y=0 and y=26. The playable area is x 1..47, y 1..25.
- Initial snake: segment 0 at (24,13), segment 1 at (23,13), segment 2 at (22,13). Direction is RIGHT. Display bits [2:0]=1 and all other bits are 0. Unused segments hold (0,0).
- Direction encoding: UP=00, RIGHT=01, DOWN=10, LEFT=11.
- Direction register:
  - `dir_next` captures the key request in any state.
  - Priority when keys are simultaneous: up > right > down > left.
  - A request opposite to `dir_cur` is ignored.
  - `dir_cur` <= `dir_next` only on an applied step.
- State machine:
  - INITIALIZING: `key_start` loads the initial snake and moves to PLAYING.
  - PLAYING: `key_start` moves to PAUSED. Each `step_tick` performs a step (below).
  - PAUSED: `key_start` returns to PLAYING. Ticks are ignored.
  - DIE_FLASHING: each `step_tick` increments `flash_cnt` and toggles all bits in the range [len-1:0] of `snake_piece_is_display`. When `flash_cnt` reaches `FLASH_TICKS-1` on a tick, the block reloads the initial snake, clears the counter and moves to INITIALIZING.
- Step, performed in PLAYING only:
  - `new_head` = head + unit vector of `dir_next`; the vector is computed in 6-bit arithmetic.
  - Collision if `new_head` is a border cell, or if it equals segment k for any k in 0..len-2 with the segment's display bit set. The tail (k=len-1) vacates and is excluded.
  - On collision, positions are unchanged and the next state is DIE_FLASHING.
  - Otherwise, segment[i] <= segment[i-1] for i=1..MAX_LEN-1, and segment 0 <= `new_head`.
  - If `new_head` == apple: `apple_eaten`=1, and if len<MAX_LEN then len+1 and display bit [len] <= 1. At len=MAX_LEN there is no growth, but the pulse still fires.
- `key_start` and `step_tick` in the same cycle: `key_start` wins and the tick is dropped.

## Timing
- All outputs are registered. The step result is visible one cycle after the `step_tick` cycle. `apple_eaten` asserts in that same cycle for exactly one cycle.
- Reset values:
  - status INITIALIZING
  - initial snake loaded
  - `snake_len`=3
  - `apple_eaten`=0
  - `flash_cnt`=0
  - `dir_cur`=`dir_next`=RIGHT
- Reset asserted mid-step or mid-flash forces the reset values immediately, asynchronously.
- `step_tick` back-to-back on consecutive cycles is legal, and each tick is a full step.
- The apple inputs are sampled in the `step_tick` cycle only.

## Structure
- `snake_pkg` holds:
  - status and direction localparams
  - grid bounds (X_MAX=48, Y_MAX=26)
  - initial head coordinates
  - MAX_LEN
- Sub-module `snake_collision_check`: combinational. Its inputs are `new_head`, the packed body, the display vector and len. Its outputs are `hit_self` and `hit_border`.

## Test plan
- Reset, then pulse `key_start`: status 01, head (24,13), len 3, display 0x00000007.
- Playing with no keys, 4 ticks: head (28,13); segment 2 at (26,13).
- At head (24,13) moving RIGHT, pulse `key_left` then tick: the request is ignored and the head moves to (25,13).
- Apple at (25,13), tick: `apple_eaten` pulses once, len 4, display 0x0000000F, segment 3 at (22,13).
- Steer the head to (47,y) and tick RIGHT: status 10, positions frozen. After 8 ticks the display alternates 0/mask, then status 11 with the initial snake reloaded.
- While PLAYING, pulse `key_start` together with `step_tick`: status 00 and the head is unmoved. Pulse `key_start` again: status 01.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game core.
// Status/direction encodings match the display stage.
package snake_pkg;

  typedef enum logic [1:0] {
    PAUSED       = 2'b00,
    PLAYING      = 2'b01,
    DIE_FLASHING = 2'b10,
    INITIALIZING = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    RIGHT = 2'b01,
    DOWN  = 2'b10,
    LEFT  = 2'b11
  } dir_e;

  localparam logic [5:0] X_MAX  = 6'd48;
  localparam logic [5:0] Y_MAX  = 6'd26;
  localparam logic [5:0] INIT_X = 6'd24;
  localparam logic [5:0] INIT_Y = 6'd13;
  localparam int         LEN_MAX = 32;

  typedef struct packed {
    logic [5:0] x;
    logic [5:0] y;
  } cell_t;

  // Opposite directions differ only in bit 1.
  function automatic dir_e opposite(input dir_e d);
    return dir_e'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/snake_collision_check.sv
// Combinational border and self-collision test for the next head.
// The tail cell (len-1) vacates on a move and is excluded.
module snake_collision_check
  import snake_pkg::*;
#(
  parameter int MAX_LEN = LEN_MAX
) (
  input  cell_t                  new_head,
  input  logic [MAX_LEN*6-1:0]   body_x,
  input  logic [MAX_LEN*6-1:0]   body_y,
  input  logic [MAX_LEN-1:0]     display,
  input  logic [5:0]             len,
  output logic                   hit_self,
  output logic                   hit_border
);

  always_comb begin
    hit_self = 1'b0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (k + 1 < int'(len) && display[k] &&
          body_x[6*k +: 6] == new_head.x &&
          body_y[6*k +: 6] == new_head.y)
        hit_self = 1'b1;
    end
  end

  assign hit_border = new_head.x == 6'd0  ||
                      new_head.x == X_MAX ||
                      new_head.y == 6'd0  ||
                      new_head.y == Y_MAX;

endmodule

// File: rtl/snake_engine.sv
// Snake body, direction, growth and game-status sequencing.
// Outputs are registered and feed the VGA display stage.
module snake_engine
  import snake_pkg::*;
#(
  parameter int MAX_LEN     = LEN_MAX,
  parameter int INIT_LEN    = 3,
  parameter int FLASH_TICKS = 8
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 step_tick,
  input  logic                 key_up,
  input  logic                 key_right,
  input  logic                 key_down,
  input  logic                 key_left,
  input  logic                 key_start,
  input  logic [5:0]           apple_x,
  input  logic [5:0]           apple_y,
  output logic [MAX_LEN*6-1:0] snake_x_temp,
  output logic [MAX_LEN*6-1:0] snake_y_temp,
  output logic [MAX_LEN-1:0]   snake_piece_is_display,
  output logic [1:0]           game_status,
  output logic                 apple_eaten,
  output logic [5:0]           snake_len
);

  localparam int FW = $clog2(FLASH_TICKS + 1);

  function automatic logic [MAX_LEN*6-1:0] init_bus(
    input logic [5:0] start,
    input logic       slide
  );
    logic [MAX_LEN*6-1:0] r;
    r = '0;
    for (int i = 0; i < INIT_LEN; i++)
      r[6*i +: 6] = start - (slide ? 6'(i) : 6'd0);
    return r;
  endfunction

  localparam logic [MAX_LEN*6-1:0] INIT_XS = init_bus(INIT_X, 1'b1);
  localparam logic [MAX_LEN*6-1:0] INIT_YS = init_bus(INIT_Y, 1'b0);
  localparam logic [MAX_LEN-1:0] INIT_DISP =
    MAX_LEN'((64'd1 << INIT_LEN) - 64'd1);

  status_e              state, state_d;
  dir_e                 dir_cur, dir_next, key_dir;
  logic                 key_any;
  logic [FW-1:0]        flash_cnt;
  cell_t                head, new_head;
  logic                 hit_self, hit_border, collide;
  logic                 tick, step, flash_end, load;
  logic [MAX_LEN-1:0]   len_mask;

  assign game_status = state;
  assign head        = {snake_x_temp[5:0], snake_y_temp[5:0]};

  // key_start wins over a coincident tick.
  assign tick      = step_tick & ~key_start;
  assign step      = state == PLAYING && tick;
  assign collide   = hit_self | hit_border;
  assign flash_end = state == DIE_FLASHING && tick &&
                     flash_cnt == FW'(FLASH_TICKS - 1);
  assign load      = (state == INITIALIZING && key_start) || flash_end;
  assign len_mask  = MAX_LEN'((64'd1 << snake_len) - 64'd1);

  always_comb begin
    key_any = key_up | key_right | key_down | key_left;
    key_dir = LEFT;
    if (key_up)         key_dir = UP;
    else if (key_right) key_dir = RIGHT;
    else if (key_down)  key_dir = DOWN;
  end

  always_comb begin
    new_head = head;
    unique case (dir_next)
      UP:    new_head.y = head.y - 6'd1;
      RIGHT: new_head.x = head.x + 6'd1;
      DOWN:  new_head.y = head.y + 6'd1;
      LEFT:  new_head.x = head.x - 6'd1;
    endcase
  end

  snake_collision_check #(.MAX_LEN(MAX_LEN)) u_coll (
    .new_head   (new_head),
    .body_x     (snake_x_temp),
    .body_y     (snake_y_temp),
    .display    (snake_piece_is_display),
    .len        (snake_len),
    .hit_self   (hit_self),
    .hit_border (hit_border)
  );

  always_comb begin
    state_d = state;
    unique case (state)
      INITIALIZING: if (key_start) state_d = PLAYING;
      PLAYING:
        if (key_start)           state_d = PAUSED;
        else if (step && collide) state_d = DIE_FLASHING;
      PAUSED:       if (key_start) state_d = PLAYING;
      DIE_FLASHING: if (flash_end) state_d = INITIALIZING;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= INITIALIZING;
    else        state <= state_d;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      snake_x_temp           <= INIT_XS;
      snake_y_temp           <= INIT_YS;
      snake_piece_is_display <= INIT_DISP;
      snake_len              <= 6'(INIT_LEN);
      apple_eaten            <= 1'b0;
      flash_cnt              <= '0;
      dir_cur                <= RIGHT;
      dir_next               <= RIGHT;
    end else begin
      apple_eaten <= 1'b0;
      if (key_any && key_dir != opposite(dir_cur))
        dir_next <= key_dir;
      if (load) begin
        snake_x_temp           <= INIT_XS;
        snake_y_temp           <= INIT_YS;
        snake_piece_is_display <= INIT_DISP;
        snake_len              <= 6'(INIT_LEN);
        flash_cnt              <= '0;
        dir_cur                <= RIGHT;
        dir_next               <= RIGHT;
      end else if (step && !collide) begin
        snake_x_temp <= {snake_x_temp[MAX_LEN*6-7:0], new_head.x};
        snake_y_temp <= {snake_y_temp[MAX_LEN*6-7:0], new_head.y};
        dir_cur      <= dir_next;
        if (new_head.x == apple_x && new_head.y == apple_y) begin
          apple_eaten <= 1'b1;
          if (snake_len < 6'(MAX_LEN)) begin
            snake_len <= snake_len + 6'd1;
            snake_piece_is_display <= snake_piece_is_display |
              MAX_LEN'(64'd1 << snake_len);
          end
        end
      end else if (state == DIE_FLASHING && tick) begin
        flash_cnt              <= flash_cnt + 1'b1;
        snake_piece_is_display <= snake_piece_is_display ^ len_mask;
      end
    end
  end

endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine: vector table, corner sequences,
// and randomized play against a cell-list reference model.
module tb_snake_engine;

  logic         clock = 1'b0;
  logic         rst_n = 1'b0;
  logic         step_tick = 1'b0, key_start = 1'b0;
  logic         key_up = 1'b0, key_right = 1'b0;
  logic         key_down = 1'b0, key_left = 1'b0;
  logic [5:0]   apple_x = 6'd1, apple_y = 6'd1;
  logic [191:0] snake_x_temp, snake_y_temp;
  logic [31:0]  snake_piece_is_display;
  logic [1:0]   game_status;
  logic         apple_eaten;
  logic [5:0]   snake_len;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  snake_engine #(.MAX_LEN(32), .INIT_LEN(3), .FLASH_TICKS(8)) dut (
    .clock                  (clock),
    .rst_n                  (rst_n),
    .step_tick              (step_tick),
    .key_up                 (key_up),
    .key_right              (key_right),
    .key_down               (key_down),
    .key_left               (key_left),
    .key_start              (key_start),
    .apple_x                (apple_x),
    .apple_y                (apple_y),
    .snake_x_temp           (snake_x_temp),
    .snake_y_temp           (snake_y_temp),
    .snake_piece_is_display (snake_piece_is_display),
    .game_status            (game_status),
    .apple_eaten            (apple_eaten),
    .snake_len              (snake_len)
  );

  // Reference model: cell list, status 0..3, directions 0..3.
  int          bx[32], by[32];
  int          mlen, mst, mdcur, mdnext, mfc;
  logic [31:0] mdisp;
  logic        meat;

  function automatic int dx(input int d);
    return (d == 1) ? 1 : (d == 3) ? -1 : 0;
  endfunction

  function automatic int dy(input int d);
    return (d == 2) ? 1 : (d == 0) ? -1 : 0;
  endfunction

  function automatic int nhx();
    return (bx[0] + dx(mdnext)) & 63;
  endfunction

  function automatic int nhy();
    return (by[0] + dy(mdnext)) & 63;
  endfunction

  task automatic model_reload();
    for (int i = 0; i < 32; i++) begin
      bx[i] = (i < 3) ? 24 - i : 0;
      by[i] = (i < 3) ? 13 : 0;
    end
    mlen = 3; mdisp = 32'h7; mfc = 0;
    mdcur = 1; mdnext = 1;
  endtask

  task automatic model_reset();
    model_reload();
    mst = 3; meat = 1'b0;
  endtask

  task automatic model_step(input logic u, r, d, l, s, t,
                            input int ax, ay);
    int old_cur, old_next, req, nx, ny;
    logic coll;
    logic [63:0] m;
    old_cur = mdcur; old_next = mdnext;
    meat = 1'b0;
    if (u | r | d | l) begin
      req = u ? 0 : r ? 1 : d ? 2 : 3;
      if (req != (old_cur + 2) % 4) mdnext = req;
    end
    case (mst)
      3: if (s) begin model_reload(); mst = 1; end
      0: if (s) mst = 1;
      1: if (s) mst = 0;
         else if (t) begin
           nx = (bx[0] + dx(old_next)) & 63;
           ny = (by[0] + dy(old_next)) & 63;
           coll = nx == 0 || nx == 48 || ny == 0 || ny == 26;
           for (int k = 0; k < mlen - 1; k++)
             if (mdisp[k] && bx[k] == nx && by[k] == ny) coll = 1'b1;
           if (coll) mst = 2;
           else begin
             for (int i = 31; i > 0; i--) begin
               bx[i] = bx[i-1]; by[i] = by[i-1];
             end
             bx[0] = nx; by[0] = ny;
             mdcur = old_next;
             if (nx == ax && ny == ay) begin
               meat = 1'b1;
               if (mlen < 32) begin mdisp[mlen] = 1'b1; mlen++; end
             end
           end
         end
      default: if (t && !s) begin
        if (mfc == 7) begin model_reload(); mst = 3; end
        else begin
          mfc++;
          m = (64'd1 << mlen) - 64'd1;
          mdisp ^= m[31:0];
        end
      end
    endcase
  endtask

  task automatic chk(input string name, input logic [191:0] act,
                     input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    logic [191:0] xs, ys;
    xs = '0; ys = '0;
    for (int i = 0; i < 32; i++) begin
      xs[6*i +: 6] = 6'(bx[i]);
      ys[6*i +: 6] = 6'(by[i]);
    end
    chk("status", game_status, mst);
    chk("len", snake_len, mlen);
    chk("eaten", apple_eaten, meat);
    chk("display", snake_piece_is_display, mdisp);
    chk("body_x", snake_x_temp, xs);
    chk("body_y", snake_y_temp, ys);
  endtask

  task automatic cyc(input logic u, r, d, l, s, t, input int ax, ay);
    key_up = u; key_right = r; key_down = d; key_left = l;
    key_start = s; step_tick = t;
    apple_x = 6'(ax); apple_y = 6'(ay);
    @(posedge clock);
    model_step(u, r, d, l, s, t, ax, ay);
    #1;
    check_model();
  endtask

  task automatic press(input int d);
    cyc(d == 0, d == 1, d == 2, d == 3, 0, 0, 1, 1);
  endtask

  task automatic ticks(input int n, input logic feed);
    for (int i = 0; i < n; i++)
      cyc(0, 0, 0, 0, 0, 1, feed ? nhx() : 1, feed ? nhy() : 1);
  endtask

  typedef struct {
    logic u, r, d, l, s, t;
    int ax, ay, rep, st, hx, hy, ln, eat;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0,0,0,0,1,0,  1, 1,  1, 1, 24, 13, 3, 0};
    tbl[1]  = '{0,0,0,1,0,0,  1, 1,  1, 1, 24, 13, 3, 0};
    tbl[2]  = '{0,0,0,0,0,1,  1, 1,  1, 1, 25, 13, 3, 0};
    tbl[3]  = '{0,0,0,0,0,1,  1, 1,  3, 1, 28, 13, 3, 0};
    tbl[4]  = '{0,0,0,0,0,1, 29,13,  1, 1, 29, 13, 4, 1};
    tbl[5]  = '{0,0,0,0,0,0,  1, 1,  1, 1, 29, 13, 4, 0};
    tbl[6]  = '{0,0,0,0,1,1,  1, 1,  1, 0, 29, 13, 4, 0};
    tbl[7]  = '{0,0,0,0,0,1,  1, 1,  2, 0, 29, 13, 4, 0};
    tbl[8]  = '{0,0,0,0,1,0,  1, 1,  1, 1, 29, 13, 4, 0};
    tbl[9]  = '{0,0,0,0,0,1,  1, 1, 18, 1, 47, 13, 4, 0};
    tbl[10] = '{0,0,0,0,0,1,  1, 1,  1, 2, 47, 13, 4, 0};
    tbl[11] = '{0,0,0,0,0,1,  1, 1,  7, 2, 47, 13, 4, 0};
    tbl[12] = '{0,0,0,0,0,1,  1, 1,  1, 3, 24, 13, 3, 0};

    model_reset();
    #12 rst_n = 1'b1;
    #1;
    chk("reset_status", game_status, 3);
    chk("reset_len", snake_len, 3);
    chk("reset_disp", snake_piece_is_display, 32'h7);
    chk("reset_head_x", snake_x_temp[5:0], 24);
    chk("reset_eaten", apple_eaten, 0);
    check_model();

    foreach (tbl[i]) begin
      for (int j = 0; j < tbl[i].rep; j++)
        cyc(tbl[i].u, tbl[i].r, tbl[i].d, tbl[i].l, tbl[i].s,
            tbl[i].t, tbl[i].ax, tbl[i].ay);
      chk($sformatf("vec%0d_status", i), game_status, tbl[i].st);
      chk($sformatf("vec%0d_hx", i), snake_x_temp[5:0], tbl[i].hx);
      chk($sformatf("vec%0d_hy", i), snake_y_temp[5:0], tbl[i].hy);
      chk($sformatf("vec%0d_len", i), snake_len, tbl[i].ln);
      chk($sformatf("vec%0d_eat", i), apple_eaten, tbl[i].eat);
    end

    // Length 5 hooks back onto segment 3: self collision.
    cyc(0, 0, 0, 0, 1, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 1, 25, 13);
    cyc(0, 0, 0, 0, 0, 1, 26, 13);
    press(0); ticks(1, 0);
    press(3); ticks(1, 0);
    press(2); ticks(1, 0);
    chk("self_hit_status", game_status, 2);
    chk("self_hit_head_y", snake_y_temp[5:0], 12);
    ticks(8, 0);
    chk("flash_done_status", game_status, 3);

    // Feed every step until length saturates.
    cyc(0, 0, 0, 0, 1, 0, 1, 1);
    ticks(20, 1);
    press(0); ticks(1, 1);
    press(3); ticks(15, 1);
    chk("max_len", snake_len, 32);
    chk("max_len_eaten", apple_eaten, 1);
    chk("max_len_disp", snake_piece_is_display, 32'hffff_ffff);

    // Asynchronous reset while a tick is pending.
    step_tick = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_status", game_status, 3);
    chk("async_len", snake_len, 3);
    chk("async_disp", snake_piece_is_display, 32'h7);
    chk("async_head_x", snake_x_temp[5:0], 24);
    model_reset();
    check_model();
    #2 step_tick = 1'b0;
    rst_n = 1'b1;

    // Length 4: the vacating tail cell is not a collision.
    cyc(0, 0, 0, 0, 1, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 1, 25, 13);
    press(0); ticks(1, 0);
    press(3); ticks(1, 0);
    press(2); ticks(1, 0);
    chk("tail_status", game_status, 1);
    chk("tail_head_x", snake_x_temp[5:0], 24);
    chk("tail_head_y", snake_y_temp[5:0], 13);

    for (int n = 0; n < 3000; n++) begin
      logic u, r, d, l, s, t;
      int ax, ay;
      u = $urandom_range(0, 3) == 0;
      r = $urandom_range(0, 3) == 0;
      d = $urandom_range(0, 3) == 0;
      l = $urandom_range(0, 3) == 0;
      s = $urandom_range(0, 39) == 0;
      t = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 1) == 1) begin
        ax = nhx(); ay = nhy();
      end else begin
        ax = $urandom_range(0, 63); ay = $urandom_range(0, 63);
      end
      cyc(u, r, d, l, s, t, ax, ay);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
